// File: rtl/seq_muldiv_unit_if.sv
// ---------------------------------------------------------------------------
// seq_muldiv_unit_if
// Issue/result bundle between the control unit and the multi-cycle
// multiply/divide engine.
//   start      issue request (sampled only while the engine is idle)
//   op         0=MUL 1=DIV 2=MOD 3=illegal
//   x_in/y_in  operands (multiplicand/dividend, multiplier/divisor)
//   result     MUL low half, DIV quotient, MOD remainder
//   result_hi  MUL high half, zero otherwise
//   ALU_ready  one-cycle completion pulse
//   flags      {V,C,N,Z}
// master = control-unit side, slave = engine side.
// ---------------------------------------------------------------------------
interface seq_muldiv_unit_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] x_in;
    logic [WIDTH-1:0] y_in;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             ALU_ready;
    logic [3:0]       flags;

    modport master (
        output start, op, x_in, y_in,
        input  result, result_hi, ALU_ready, flags
    );

    modport slave (
        input  start, op, x_in, y_in,
        output result, result_hi, ALU_ready, flags
    );
endinterface

// File: rtl/seq_muldiv_unit.sv
// ---------------------------------------------------------------------------
// seq_muldiv_unit
// Multi-cycle unsigned multiply / divide / modulo engine. Normal operations
// take WIDTH iterations (one per cycle); divide-by-zero and the illegal
// opcode finish immediately. ALU_ready pulses for one cycle in DONE, when
// result/result_hi/flags have just been updated.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-low
//   bus    seq_muldiv_unit_if slave (start/op/x_in/y_in in,
//          result/result_hi/ALU_ready/flags out)
// ---------------------------------------------------------------------------
module seq_muldiv_unit #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               reset,
    seq_muldiv_unit_if.slave   bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    localparam logic [1:0] OP_MUL = 2'd0;
    localparam logic [1:0] OP_DIV = 2'd1;
    localparam logic [1:0] OP_MOD = 2'd2;
    localparam logic [1:0] OP_ILL = 2'd3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state;
    logic [CW-1:0]    counter;
    logic [1:0]       op_q;
    // MUL: acc_hi = running high half, acc_lo = multiplier shifting out /
    //      product low half shifting in, opnd_b = multiplicand.
    // DIV: acc_hi = partial remainder, acc_lo = dividend shifting out /
    //      quotient shifting in, opnd_b = divisor.
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] opnd_b;

    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] result_hi_q;
    logic [3:0]       flags_q;

    // ---------------- one iteration of the datapath ----------------
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;   // WIDTH+1-bit partial remainder
    logic             div_fits;
    logic [WIDTH-1:0] div_rem;
    logic [WIDTH-1:0] nxt_hi;
    logic [WIDTH-1:0] nxt_lo;

    // NOTE: every always_comb output gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_b} : '0);
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_fits  = (div_shift >= {1'b0, opnd_b});
        // The true difference is below the divisor, so WIDTH bits suffice.
        div_rem   = div_shift[WIDTH-1:0] - opnd_b;
        nxt_hi    = acc_hi;
        nxt_lo    = acc_lo;
        if (op_q == OP_MUL) begin
            nxt_hi = mul_sum[WIDTH:1];
            nxt_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
        end else if (div_fits) begin
            nxt_hi = div_rem;
            nxt_lo = {acc_lo[WIDTH-2:0], 1'b1};
        end else begin
            nxt_hi = div_shift[WIDTH-1:0];
            nxt_lo = {acc_lo[WIDTH-2:0], 1'b0};
        end
    end

    // ---------------- completion values ----------------
    logic             fast_done;   // skip BUSY: illegal op or divide by zero
    logic             fin_load;
    logic [WIDTH-1:0] fin_res;
    logic [WIDTH-1:0] fin_hi;
    logic             fin_c;
    logic             fin_v;

    always_comb begin
        fast_done = (bus.op == OP_ILL) ||
                    ((bus.op != OP_MUL) && (bus.y_in == '0));
        fin_load  = 1'b0;
        fin_res   = '0;
        fin_hi    = '0;
        fin_c     = 1'b0;
        fin_v     = 1'b0;
        if (state == ST_IDLE && bus.start && fast_done) begin
            fin_load = 1'b1;
            if (bus.op == OP_DIV) begin
                fin_res = '1;
                fin_v   = 1'b1;
            end else if (bus.op == OP_MOD) begin
                fin_res = bus.x_in;
                fin_v   = 1'b1;
            end
        end else if (state == ST_BUSY && counter == LAST_ITER) begin
            fin_load = 1'b1;
            case (op_q)
                OP_MUL: begin
                    fin_res = nxt_lo;
                    fin_hi  = nxt_hi;
                    fin_c   = (nxt_hi != '0);
                    fin_v   = (nxt_hi != '0);
                end
                OP_DIV:  fin_res = nxt_lo;
                default: fin_res = nxt_hi;
            endcase
        end
    end

    // ---------------- control and architectural outputs ----------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= ST_IDLE;
            counter     <= '0;
            result_q    <= '0;
            result_hi_q <= '0;
            flags_q     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        counter <= '0;
                        state   <= fast_done ? ST_DONE : ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    counter <= counter + 1'b1;
                    if (counter == LAST_ITER) begin
                        state <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
            if (fin_load) begin
                result_q    <= fin_res;
                result_hi_q <= fin_hi;
                flags_q     <= {fin_v, fin_c, fin_res[WIDTH-1], fin_res == '0};
            end
        end
    end

    // NOTE: the operand/accumulator registers are left unreset on purpose;
    // they are always loaded at issue before anything reads them.
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && bus.start) begin
            op_q   <= bus.op;
            acc_hi <= '0;
            if (bus.op == OP_MUL) begin
                acc_lo <= bus.y_in;
                opnd_b <= bus.x_in;
            end else begin
                acc_lo <= bus.x_in;
                opnd_b <= bus.y_in;
            end
        end else if (state == ST_BUSY) begin
            acc_hi <= nxt_hi;
            acc_lo <= nxt_lo;
        end
    end

    assign bus.result    = result_q;
    assign bus.result_hi = result_hi_q;
    assign bus.flags     = flags_q;
    assign bus.ALU_ready = (state == ST_DONE);

endmodule
